controle_pipeline: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline. It drives the load-enable and flush (bubble-insert) controls of the four 32-bit stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It tracks which stages hold valid instructions, resolves load-use, taken-branch and data-memory-busy hazards with fixed priority, and keeps saturating event counters plus a sticky memory-timeout flag.

---
 rtl/controle_pipeline.sv | 187 ++++++++++++++++++
 tb/tb_controle_pipeline.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_pipeline.sv
// Hazard and sequencing controller for a 5-stage pipeline.
// It drives the load-enable and flush controls of the IF/ID, ID/EX, EX/MEM
// and MEM/WB registers and the PC enable. It tracks which stages hold valid
// instructions and resolves hazards with a fixed priority:
// memory freeze > taken branch > load-use bubble > normal run.
// It also keeps saturating event counters and a sticky memory-timeout flag.

module controle_pipeline #(
    parameter int LARGURA_CNT = 16,
    parameter int LIMITE_MEM  = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_usa_rs,
    input  logic                   id_usa_rt,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_le_mem,
    input  logic                   desvio_tomado,
    input  logic                   mem_ocupada,
    output logic                   en_pc,
    output logic                   en_if_id,
    output logic                   en_id_ex,
    output logic                   en_ex_mem,
    output logic                   en_mem_wb,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic                   flush_mem_wb,
    output logic                   sel_pc_desvio,
    output logic [3:0]             valido,
    output logic [LARGURA_CNT-1:0] cnt_bolhas,
    output logic [LARGURA_CNT-1:0] cnt_congela,
    output logic [LARGURA_CNT-1:0] cnt_desvios,
    output logic                   erro_mem
);

    // Width of the freeze run-length counter: just enough to hold LIMITE_MEM.
    localparam int LARG_RUN = (LIMITE_MEM < 2) ? 1 : $clog2(LIMITE_MEM + 1);
    localparam logic [LARG_RUN-1:0] RUN_LIMITE = LARG_RUN'(LIMITE_MEM);

    // Action selected for the current cycle. Exactly one applies.
    typedef enum logic [1:0] {
        ACAO_RUN,
        ACAO_BOLHA,
        ACAO_DESVIO,
        ACAO_CONGELA
    } acao_t;

    acao_t                 acao;
    logic                  congela;
    logic                  desvio;
    logic                  bolha;
    logic                  dep_rs;
    logic                  dep_rt;
    logic [3:0]            valido_next;
    logic [LARG_RUN-1:0]   run_len;
    logic [LARG_RUN-1:0]   run_len_inc;

    // Hazards only count when the stages involved hold real instructions,
    // so an empty pipe (e.g. right after reset) always runs.
    assign congela = mem_ocupada & valido[2];
    assign desvio  = desvio_tomado & valido[1];
    assign dep_rs  = id_usa_rs & (id_rs == ex_rd);
    assign dep_rt  = id_usa_rt & (id_rt == ex_rd);
    assign bolha   = ex_le_mem & valido[1] & valido[0] & (ex_rd != 5'd0)
                   & (dep_rs | dep_rt);

    // Fixed-priority selection of the cycle's action.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        acao = ACAO_RUN;
        if (congela) begin
            acao = ACAO_CONGELA;
        end else if (desvio) begin
            acao = ACAO_DESVIO;
        end else if (bolha) begin
            acao = ACAO_BOLHA;
        end
    end

    // Decode the action into register enables, flushes and PC select.
    always_comb begin
        en_pc         = 1'b1;
        en_if_id      = 1'b1;
        en_id_ex      = 1'b1;
        en_ex_mem     = 1'b1;
        en_mem_wb     = 1'b1;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_mem_wb  = 1'b0;
        sel_pc_desvio = 1'b0;
        unique case (acao)
            ACAO_CONGELA: begin
                // Everything up to MEM holds; WB gets a bubble so the MEM
                // instruction's writeback is never repeated.
                en_pc        = 1'b0;
                en_if_id     = 1'b0;
                en_id_ex     = 1'b0;
                en_ex_mem    = 1'b0;
                flush_mem_wb = 1'b1;
            end
            ACAO_DESVIO: begin
                // Squash the two younger instructions and redirect fetch.
                flush_if_id   = 1'b1;
                flush_id_ex   = 1'b1;
                sel_pc_desvio = 1'b1;
            end
            ACAO_BOLHA: begin
                // IF and ID hold for one cycle while a NOP enters EX.
                en_pc       = 1'b0;
                en_if_id    = 1'b0;
                flush_id_ex = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Next valid bits: hold when disabled, clear when flushed, else shift in.
    always_comb begin
        valido_next = valido;
        if (en_if_id) begin
            valido_next[0] = ~flush_if_id;
        end
        if (en_id_ex) begin
            valido_next[1] = flush_id_ex ? 1'b0 : valido[0];
        end
        if (en_ex_mem) begin
            valido_next[2] = valido[1];
        end
        if (en_mem_wb) begin
            valido_next[3] = flush_mem_wb ? 1'b0 : valido[2];
        end
    end

    // Valid-bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of the others.
        if (!rst_n) begin
            valido <= 4'b0000;
        end else begin
            valido <= valido_next;
        end
    end

    // Saturating event counters, one per hazard action.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_bolhas  <= '0;
            cnt_congela <= '0;
            cnt_desvios <= '0;
        end else begin
            if ((acao == ACAO_BOLHA) && (cnt_bolhas != '1)) begin
                cnt_bolhas <= cnt_bolhas + LARGURA_CNT'(1);
            end
            if ((acao == ACAO_CONGELA) && (cnt_congela != '1)) begin
                cnt_congela <= cnt_congela + LARGURA_CNT'(1);
            end
            if ((acao == ACAO_DESVIO) && (cnt_desvios != '1)) begin
                cnt_desvios <= cnt_desvios + LARGURA_CNT'(1);
            end
        end
    end

    // The run-length stops at the limit so a very long freeze cannot wrap it.
    assign run_len_inc = (run_len == RUN_LIMITE) ? run_len
                                                 : run_len + LARG_RUN'(1);

    // Consecutive-freeze tracking and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len  <= '0;
            erro_mem <= 1'b0;
        end else if (acao == ACAO_CONGELA) begin
            run_len <= run_len_inc;
            if (run_len_inc == RUN_LIMITE) begin
                erro_mem <= 1'b1;
            end
        end else begin
            run_len <= '0;
        end
    end

endmodule

// File: tb/tb_controle_pipeline.sv
// Self-checking bench for controle_pipeline.
// Table of input vectors with hand-derived control outputs and next valid
// bits; the expected valid bits go through a scoreboard queue and are
// compared after the clock edge. Counters, timeout, saturation and reset
// corner cases are covered by short hand-written sequences.

module tb_controle_pipeline;

    localparam int LC = 4;
    localparam int LM = 4;

    // {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
    //  flush_if_id, flush_id_ex, flush_mem_wb, sel_pc_desvio}
    localparam logic [8:0] C_RUN     = 9'b11111_000_0;
    localparam logic [8:0] C_CONGELA = 9'b00001_001_0;
    localparam logic [8:0] C_DESVIO  = 9'b11111_110_1;
    localparam logic [8:0] C_BOLHA   = 9'b00111_010_0;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       usa_rs;
        logic       usa_rt;
        logic [4:0] rd;
        logic       le;
        logic       desv;
        logic       ocup;
        logic [8:0] ctrl;
        logic [3:0] val;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [4:0]    id_rs = '0, id_rt = '0, ex_rd = '0;
    logic          id_usa_rs = 1'b0, id_usa_rt = 1'b0;
    logic          ex_le_mem = 1'b0, desvio_tomado = 1'b0, mem_ocupada = 1'b0;
    logic          en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
    logic          flush_if_id, flush_id_ex, flush_mem_wb, sel_pc_desvio;
    logic [3:0]    valido;
    logic [LC-1:0] cnt_bolhas, cnt_congela, cnt_desvios;
    logic          erro_mem;
    logic [8:0]    ctrl;

    int            checks = 0;
    int            failures = 0;
    vec_t          tab[$];
    logic [3:0]    sb[$];

    controle_pipeline #(.LARGURA_CNT(LC), .LIMITE_MEM(LM)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_usa_rs(id_usa_rs), .id_usa_rt(id_usa_rt),
        .ex_rd(ex_rd), .ex_le_mem(ex_le_mem),
        .desvio_tomado(desvio_tomado), .mem_ocupada(mem_ocupada),
        .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
        .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_mem_wb(flush_mem_wb), .sel_pc_desvio(sel_pc_desvio),
        .valido(valido),
        .cnt_bolhas(cnt_bolhas), .cnt_congela(cnt_congela),
        .cnt_desvios(cnt_desvios), .erro_mem(erro_mem)
    );

    assign ctrl = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                   flush_if_id, flush_id_ex, flush_mem_wb, sel_pc_desvio};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [4:0] rs,
                                input logic [4:0] rt, input logic usa_rs,
                                input logic usa_rt, input logic [4:0] rd,
                                input logic le, input logic desv,
                                input logic ocup, input logic [8:0] c,
                                input logic [3:0] v);
        vec_t r;
        r.name = n; r.rs = rs; r.rt = rt; r.usa_rs = usa_rs; r.usa_rt = usa_rt;
        r.rd = rd; r.le = le; r.desv = desv; r.ocup = ocup; r.ctrl = c;
        r.val = v;
        return r;
    endfunction

    task automatic drive_idle();
        id_rs = '0; id_rt = '0; id_usa_rs = 1'b0; id_usa_rt = 1'b0;
        ex_rd = '0; ex_le_mem = 1'b0; desvio_tomado = 1'b0; mem_ocupada = 1'b0;
    endtask

    // Called just after a falling edge: drive, check controls, cross the
    // rising edge, check valid bits, and return at the next falling edge.
    task automatic apply(input vec_t v);
        logic [3:0] exp_v;
        id_rs = v.rs; id_rt = v.rt; id_usa_rs = v.usa_rs; id_usa_rt = v.usa_rt;
        ex_rd = v.rd; ex_le_mem = v.le; desvio_tomado = v.desv;
        mem_ocupada = v.ocup;
        #1;
        check({v.name, " ctrl"}, 32'(ctrl), 32'(v.ctrl));
        sb.push_back(v.val);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({v.name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            exp_v = sb.pop_front();
            check({v.name, " valido"}, 32'(valido), 32'(exp_v));
        end
        @(negedge clk);
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(tab[i]);
    endtask

    task automatic check_cnt(input string n, input int b, input int c,
                             input int d, input logic e);
        check({n, " cnt_bolhas"},  32'(cnt_bolhas),  32'(b));
        check({n, " cnt_congela"}, 32'(cnt_congela), 32'(c));
        check({n, " cnt_desvios"}, 32'(cnt_desvios), 32'(d));
        check({n, " erro_mem"},    32'(erro_mem),    32'(e));
    endtask

    initial begin
        //                 name         rs rt urs urt rd le ds oc ctrl       val
        tab.push_back(mk("fill0",       0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0001)); // 0
        tab.push_back(mk("fill1",       0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0011));
        tab.push_back(mk("fill2",       0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0111));
        tab.push_back(mk("fill3",       0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1111));
        tab.push_back(mk("lu_rt",       0, 5, 0, 1, 5, 1, 0, 0, C_BOLHA,   4'b1101)); // 4
        tab.push_back(mk("lu_after0",   0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1011));
        tab.push_back(mk("lu_after1",   0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0111));
        tab.push_back(mk("lu_after2",   0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1111));
        tab.push_back(mk("lu_rs",       7, 0, 1, 0, 7, 1, 0, 0, C_BOLHA,   4'b1101)); // 8
        tab.push_back(mk("lu_rs_a0",    0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1011));
        tab.push_back(mk("lu_rs_a1",    0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0111));
        tab.push_back(mk("lu_rs_a2",    0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1111));
        tab.push_back(mk("no_use",      7, 7, 0, 0, 7, 1, 0, 0, C_RUN,     4'b1111)); // 12
        tab.push_back(mk("rd_zero",     0, 0, 1, 1, 0, 1, 0, 0, C_RUN,     4'b1111));
        tab.push_back(mk("not_load",    0, 5, 0, 1, 5, 0, 0, 0, C_RUN,     4'b1111));
        tab.push_back(mk("branch",      0, 0, 0, 0, 0, 0, 1, 0, C_DESVIO,  4'b1100)); // 15
        tab.push_back(mk("branch_inv",  0, 0, 0, 0, 0, 0, 1, 0, C_RUN,     4'b1001));
        tab.push_back(mk("refill0",     0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0011));
        tab.push_back(mk("refill1",     0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0111));
        tab.push_back(mk("refill2",     0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1111));
        tab.push_back(mk("branch_lu",   0, 5, 0, 1, 5, 1, 1, 0, C_DESVIO,  4'b1100)); // 20
        tab.push_back(mk("refill3",     0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1001));
        tab.push_back(mk("refill4",     0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0011));
        tab.push_back(mk("refill5",     0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0111));
        tab.push_back(mk("refill6",     0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1111));
        tab.push_back(mk("frz0",        0, 0, 0, 0, 0, 0, 0, 1, C_CONGELA, 4'b0111)); // 25
        tab.push_back(mk("frz_branch",  0, 0, 0, 0, 0, 0, 1, 1, C_CONGELA, 4'b0111));
        tab.push_back(mk("frz_lu",      0, 5, 0, 1, 5, 1, 1, 1, C_CONGELA, 4'b0111));
        tab.push_back(mk("branch_late", 0, 0, 0, 0, 0, 0, 1, 0, C_DESVIO,  4'b1100)); // 28
        tab.push_back(mk("run_a",       0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1001)); // 29
        tab.push_back(mk("busy_inv",    0, 0, 0, 0, 0, 0, 0, 1, C_RUN,     4'b0011));
        tab.push_back(mk("run_b",       0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b0111));
        tab.push_back(mk("run_c",       0, 0, 0, 0, 0, 0, 0, 0, C_RUN,     4'b1111)); // 32

        // Asynchronous reset with hazard inputs asserted: controls stay RUN.
        #1 rst_n = 1'b0;
        ex_le_mem = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_usa_rt = 1'b1;
        desvio_tomado = 1'b1; mem_ocupada = 1'b1;
        #2;
        check("reset valido", 32'(valido), 32'd0);
        check_cnt("reset", 0, 0, 0, 1'b0);
        check("reset ctrl", 32'(ctrl), 32'(C_RUN));
        repeat (2) @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        run_range(0, 3);
        check_cnt("filled", 0, 0, 0, 1'b0);
        run_range(4, 4);
        check_cnt("lu_rt", 1, 0, 0, 1'b0);
        run_range(5, 11);
        check_cnt("lu_rs", 2, 0, 0, 1'b0);
        run_range(12, 14);
        check_cnt("no_stall", 2, 0, 0, 1'b0);
        run_range(15, 15);
        check_cnt("branch", 2, 0, 1, 1'b0);
        run_range(16, 19);
        check_cnt("branch_inv", 2, 0, 1, 1'b0);
        run_range(20, 24);
        check_cnt("branch_lu", 2, 0, 2, 1'b0);
        run_range(25, 27);
        check_cnt("freeze3", 2, 3, 2, 1'b0);
        run_range(28, 28);
        check_cnt("branch_late", 2, 3, 3, 1'b0);
        run_range(29, 32);
        check_cnt("busy_inv", 2, 3, 3, 1'b0);

        // Memory timeout: flag rises on the 4th consecutive freeze edge.
        for (int k = 1; k <= 6; k++) begin
            apply(mk($sformatf("tmo%0d", k), 0, 0, 0, 0, 0, 0, 0, 1,
                     C_CONGELA, 4'b0111));
            check($sformatf("tmo%0d erro_mem", k), 32'(erro_mem),
                  32'(k >= LM));
        end
        apply(mk("tmo_drop", 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 4'b1111));
        check_cnt("tmo_drop", 2, 9, 3, 1'b1);

        // Freeze counter saturates at all-ones.
        for (int k = 1; k <= 7; k++) begin
            apply(mk($sformatf("sat%0d", k), 0, 0, 0, 0, 0, 0, 0, 1,
                     C_CONGELA, 4'b0111));
            check($sformatf("sat%0d cnt_congela", k), 32'(cnt_congela),
                  (9 + k > 15) ? 32'd15 : 32'(9 + k));
        end

        // Reset in the middle of a freeze clears everything at once.
        mem_ocupada = 1'b1;
        #1 check("midrst ctrl before", 32'(ctrl), 32'(C_CONGELA));
        #1 rst_n = 1'b0;
        #1;
        check("midrst valido", 32'(valido), 32'd0);
        check_cnt("midrst", 0, 0, 0, 1'b0);
        check("midrst ctrl", 32'(ctrl), 32'(C_RUN));
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // Run-length restarted from zero: 3 freezes do not time out, 4th does.
        run_range(0, 2);
        for (int k = 1; k <= 4; k++) begin
            apply(mk($sformatf("post%0d", k), 0, 0, 0, 0, 0, 0, 0, 1,
                     C_CONGELA, 4'b0111));
            check($sformatf("post%0d erro_mem", k), 32'(erro_mem),
                  32'(k >= LM));
        end
        check("post cnt_congela", 32'(cnt_congela), 32'd4);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against the bench stalling on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
